// File: rtl/ysyx_24080006_axi_sram.sv
// ---------------------------------------------------------------------------
// ysyx_24080006_axi_sram
//
// AXI4 slave memory model. It is the responder for the core's AXI master
// port: the NPC simulation memory, and the target when the core's AXI port
// is exercised on its own. It handles one transaction at a time and
// supports FIXED and INCR bursts; WRAP bursts are stepped like INCR.
// Read and write response latencies are set by parameters.
//
// Parameters
//   DEPTH_WORDS : number of 32-bit words in the array
//   BASE_ADDR   : byte address of word 0
//   RD_LAT      : idle cycles between the cycle after the AR handshake and
//                 the first rvalid (0 allowed)
//   WR_LAT      : idle cycles between the final W beat and bvalid (0 allowed)
//
// Ports
//   clock, reset                 : rising-edge clock, async active-high reset
//   ar*  (valid/ready/addr/id/len/size/burst) : read address channel
//   r*   (valid/ready/data/resp/last/id)      : read data channel
//   aw*  (valid/ready/addr/id/len/size/burst) : write address channel
//   w*   (valid/ready/data/strb/last)         : write data channel
//   b*   (valid/ready/resp/id)                : write response channel
//
// Responses: OKAY (00), SLVERR (10) on a wlast that disagrees with the beat
// count, DECERR (11) for any beat outside the array. DECERR takes priority
// over SLVERR.
// ---------------------------------------------------------------------------
module ysyx_24080006_axi_sram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned WR_LAT      = 1
) (
  input  logic        clock,
  input  logic        reset,
  // read address
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  // read data
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid,
  // write address
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  // write data
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  // write response
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_DATA = 3'd2,
    WR_DATA = 3'd3,
    WR_WAIT = 3'd4,
    WR_RESP = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Transaction fields latched at the address handshake
  logic [31:0] addr;
  logic [7:0]  len;
  logic [2:0]  size;
  logic [1:0]  burst;
  logic [3:0]  id;

  // Control counters
  logic [7:0]  beat;
  logic [31:0] lat_cnt;
  logic [1:0]  wr_err;
  logic [1:0]  wr_err_nxt;

  logic [31:0] mem [DEPTH_WORDS];

  // Beat address decode
  logic [31:0]      offset;
  logic [31:0]      word_idx;
  logic [IDX_W-1:0] mem_idx;
  logic             in_range;
  logic [2:0]       size_eff;
  logic [31:0]      step;
  logic [31:0]      addr_nxt;
  logic             last_beat;

  logic ar_hs;
  logic aw_hs;
  logic r_hs;
  logic w_hs;

  // The subtraction wraps modulo 2^32, so addresses below the base turn
  // into huge offsets; the explicit lower-bound compare catches them.
  assign offset    = addr - BASE_ADDR;
  assign word_idx  = offset >> 2;
  assign mem_idx   = word_idx[IDX_W-1:0];
  assign in_range  = (addr >= BASE_ADDR) && (word_idx < DEPTH_WORDS);

  // Beats wider than the 32-bit bus are stepped as full words.
  assign size_eff  = (size > 3'd2) ? 3'd2 : size;
  assign step      = 32'd1 << size_eff;
  assign addr_nxt  = (burst == 2'b00) ? addr : (addr + step);
  assign last_beat = (beat == len);

  assign ar_hs = arvalid && arready;
  assign aw_hs = awvalid && awready;
  assign r_hs  = rvalid && rready;
  assign w_hs  = wvalid && wready;

  // Error accumulation across a write burst: an out-of-range beat forces
  // DECERR, a misplaced or missing wlast only raises SLVERR if nothing
  // worse has been recorded.
  always_comb begin
    wr_err_nxt = wr_err;
    if (!in_range) begin
      wr_err_nxt = 2'b11;
    end else if ((wlast != last_beat) && (wr_err != 2'b11)) begin
      wr_err_nxt = 2'b10;
    end
  end

  // ---- state register ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- next state and handshake outputs ----
  always_comb begin
    state_nxt = state;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    rvalid    = 1'b0;
    bvalid    = 1'b0;
    unique case (state)
      IDLE: begin
        // Read wins a simultaneous request; the write waits in IDLE.
        arready = !reset;
        awready = !arvalid && !reset;
        if (arvalid && !reset) begin
          if (RD_LAT == 0) state_nxt = RD_DATA;
          else             state_nxt = RD_WAIT;
        end else if (awvalid && !reset) begin
          state_nxt = WR_DATA;
        end
      end
      RD_WAIT: begin
        if (lat_cnt == (RD_LAT - 1)) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        rvalid = 1'b1;
        if (rready && last_beat) state_nxt = IDLE;
      end
      WR_DATA: begin
        wready = 1'b1;
        // The beat count, not wlast, closes the burst.
        if (wvalid && last_beat) begin
          if (WR_LAT == 0) state_nxt = WR_RESP;
          else             state_nxt = WR_WAIT;
        end
      end
      WR_WAIT: begin
        if (lat_cnt == (WR_LAT - 1)) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        bvalid = 1'b1;
        if (bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control counters and echoed ID ----
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      beat    <= 8'd0;
      lat_cnt <= 32'd0;
      wr_err  <= 2'b00;
      id      <= 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          beat    <= 8'd0;
          lat_cnt <= 32'd0;
          if (ar_hs) begin
            id <= arid;
          end else if (aw_hs) begin
            id     <= awid;
            wr_err <= 2'b00;
          end
        end
        RD_WAIT, WR_WAIT: begin
          if (state_nxt != state) lat_cnt <= 32'd0;
          else                    lat_cnt <= lat_cnt + 32'd1;
        end
        RD_DATA: begin
          if (r_hs) beat <= beat + 8'd1;
        end
        WR_DATA: begin
          if (w_hs) begin
            beat   <= beat + 8'd1;
            wr_err <= wr_err_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // ---- transaction fields (datapath, not reset) ----
  always_ff @(posedge clock) begin
    if (ar_hs) begin
      addr  <= araddr;
      len   <= arlen;
      size  <= arsize;
      burst <= arburst;
    end else if (aw_hs) begin
      addr  <= awaddr;
      len   <= awlen;
      size  <= awsize;
      burst <= awburst;
    end else if (r_hs || w_hs) begin
      addr  <= addr_nxt;
    end
  end

  // ---- array write; out-of-range beats are dropped ----
  always_ff @(posedge clock) begin
    if (w_hs && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[mem_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read data comes straight from the array for the current beat; the
  // address only moves on a handshake, so the beat holds under backpressure.
  assign rdata = ((state == RD_DATA) && in_range) ? mem[mem_idx] : 32'h0;
  assign rresp = ((state == RD_DATA) && !in_range) ? 2'b11 : 2'b00;
  assign rlast = (state == RD_DATA) && last_beat;
  assign rid   = (state == RD_DATA) ? id : 4'd0;
  assign bresp = (state == WR_RESP) ? wr_err : 2'b00;
  assign bid   = (state == WR_RESP) ? id : 4'd0;

endmodule

// File: tb/tb_ysyx_24080006_axi_sram.sv
module tb_ysyx_24080006_axi_sram;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
  localparam int DEPTH  = 1024;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic [3:0]  rid;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic [3:0]  bid;

  ysyx_24080006_axi_sram #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (32'h8000_0000),
    .RD_LAT     (RD_LAT),
    .WR_LAT     (WR_LAT)
  ) dut (
    .clock  (clock),   .reset  (reset),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
    .arlen  (arlen),   .arsize (arsize),  .arburst(arburst),
    .rvalid (rvalid),  .rready (rready),  .rdata (rdata),  .rresp(rresp),
    .rlast  (rlast),   .rid    (rid),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
    .awlen  (awlen),   .awsize (awsize),  .awburst(awburst),
    .wvalid (wvalid),  .wready (wready),  .wdata (wdata),  .wstrb(wstrb),
    .wlast  (wlast),
    .bvalid (bvalid),  .bready (bready),  .bresp (bresp),  .bid(bid)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rbeat_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } bexp_t;

  rbeat_t rq[$];
  bexp_t  bq[$];

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] edat [8];
  logic [1:0]  eresp[8];
  logic [31:0] wdat [8];
  logic [3:0]  wstb [8];
  logic        wlst [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bad(input string tag, input string why);
    n_chk++;
    n_fail++;
    $display("FAIL %s: %s", tag, why);
  endtask

  task automatic wait_clk();
    @(posedge clock);
    #1;
  endtask

  task automatic set_w(input int k, input logic [31:0] d, input logic [3:0] s, input logic l);
    wdat[k] = d;
    wstb[k] = s;
    wlst[k] = l;
  endtask

  task automatic set_r(input int k, input logic [31:0] d, input logic [1:0] r);
    edat[k]  = d;
    eresp[k] = r;
  endtask

  // Issue an AR; expected beats come from edat/eresp. Returns 1 ns after
  // the handshake edge.
  task automatic rd_issue(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                          input logic [1:0] b, input logic [3:0] i, input bit push);
    int t;
    rbeat_t e;
    if (push) begin
      for (int k = 0; k <= int'(l); k++) begin
        e.data = edat[k];
        e.resp = eresp[k];
        e.last = (k == int'(l));
        e.id   = i;
        rq.push_back(e);
      end
    end
    araddr = a; arlen = l; arsize = s; arburst = b; arid = i; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 64) begin wait_clk(); t++; end
    if (!arready) begin
      bad("ar_handshake", "arready never rose");
      arvalid = 1'b0;
      return;
    end
    wait_clk();
    arvalid = 1'b0;
  endtask

  // Collect nbeats R beats against the scoreboard. exp_lat >= 0 checks the
  // cycle distance from the AR handshake to the first rvalid; stall > 0
  // holds rready low that many cycles on the first beat.
  task automatic rd_collect(input int nbeats, input int stall, input int exp_lat);
    int t;
    rbeat_t e;
    logic [31:0] d0;
    rready = (stall == 0);
    t = 0;
    while (!rvalid && t < 64) begin wait_clk(); t++; end
    if (!rvalid) begin
      bad("r_first", "rvalid never rose");
      rready = 1'b0;
      return;
    end
    if (exp_lat >= 0) chk("rd_latency", t + 1, exp_lat);
    if (stall > 0) begin
      d0 = rdata;
      for (int k = 0; k < stall; k++) begin
        wait_clk();
        chk("stall_rvalid", rvalid, 1'b1);
        chk("stall_rdata", rdata, d0);
      end
      rready = 1'b1;
    end
    for (int n = 0; n < nbeats; n++) begin
      t = 0;
      while (!rvalid && t < 16) begin wait_clk(); t++; end
      if (!rvalid) begin
        bad("r_beat", "rvalid missing for a beat");
        rready = 1'b0;
        return;
      end
      if (rq.size() == 0) begin
        bad("r_scoreboard", "R beat with nothing expected");
      end else begin
        e = rq.pop_front();
        chk("rdata", rdata, e.data);
        chk("rresp", rresp, e.resp);
        chk("rlast", rlast, e.last);
        chk("rid", rid, e.id);
      end
      wait_clk();
    end
    rready = 1'b0;
    chk("rvalid_drop", rvalid, 1'b0);
  endtask

  // Full write transaction from wdat/wstb/wlst; expects exp_resp on B.
  task automatic wr(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                    input logic [1:0] b, input logic [3:0] i, input logic [1:0] exp_resp);
    int t;
    bexp_t e;
    e.resp = exp_resp;
    e.id   = i;
    bq.push_back(e);
    awaddr = a; awlen = l; awsize = s; awburst = b; awid = i; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 64) begin wait_clk(); t++; end
    if (!awready) begin
      bad("aw_handshake", "awready never rose");
      awvalid = 1'b0;
      return;
    end
    wait_clk();
    awvalid = 1'b0;
    for (int k = 0; k <= int'(l); k++) begin
      wdata = wdat[k]; wstrb = wstb[k]; wlast = wlst[k]; wvalid = 1'b1;
      t = 0;
      while (!wready && t < 64) begin wait_clk(); t++; end
      if (!wready) begin
        bad("w_beat", "wready never rose");
        wvalid = 1'b0;
        return;
      end
      wait_clk();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    bready = 1'b1;
    t = 0;
    while (!bvalid && t < 64) begin wait_clk(); t++; end
    if (!bvalid) begin
      bad("b_resp", "bvalid never rose");
      bready = 1'b0;
      return;
    end
    chk("wr_latency", t, WR_LAT);
    e = bq.pop_front();
    chk("bresp", bresp, e.resp);
    chk("bid", bid, e.id);
    wait_clk();
    bready = 1'b0;
    chk("bvalid_drop", bvalid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 0; arburst = 0;
    rready  = 0;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 0; awburst = 0;
    wvalid  = 0; wdata  = 0; wstrb = 0; wlast = 0;
    bready  = 0;
    reset   = 1'b1;
    repeat (3) @(posedge clock);
    #1;

    // Reset state
    chk("rst_arready", arready, 1'b0);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_rlast", rlast, 1'b0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_rresp", rresp, 2'b00);
    chk("rst_bresp", bresp, 2'b00);
    chk("rst_rid", rid, 4'd0);
    chk("rst_bid", bid, 4'd0);
    reset = 1'b0;
    #1;
    chk("idle_arready", arready, 1'b1);
    chk("idle_awready", awready, 1'b1);
    chk("idle_wready", wready, 1'b0);

    // mem[0] = DEADBEEF, then single read with latency check
    set_w(0, 32'hDEAD_BEEF, 4'hF, 1'b1);
    wr(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd1, 2'b00);
    set_r(0, 32'hDEAD_BEEF, 2'b00);
    rd_issue(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd2, 1'b1);
    rd_collect(1, 0, 1 + RD_LAT);

    // INCR 4-beat write and readback
    for (int k = 0; k < 4; k++) set_w(k, 32'(k + 1), 4'hF, k == 3);
    wr(32'h8000_0010, 8'd3, 3'd2, 2'b01, 4'd3, 2'b00);
    for (int k = 0; k < 4; k++) set_r(k, 32'(k + 1), 2'b00);
    rd_issue(32'h8000_0010, 8'd3, 3'd2, 2'b01, 4'd4, 1'b1);
    rd_collect(4, 0, 1 + RD_LAT);

    // FIXED burst repeats one word
    for (int k = 0; k < 3; k++) set_r(k, 32'd2, 2'b00);
    rd_issue(32'h8000_0014, 8'd2, 3'd2, 2'b00, 4'd5, 1'b1);
    rd_collect(3, 0, -1);

    // arsize 3 steps as a 4-byte beat
    set_r(0, 32'd1, 2'b00);
    set_r(1, 32'd2, 2'b00);
    rd_issue(32'h8000_0010, 8'd1, 3'd3, 2'b01, 4'd6, 1'b1);
    rd_collect(2, 0, -1);

    // Byte strobes: 0100 and 0101 over 11223344, then an all-zero strobe
    set_w(0, 32'h1122_3344, 4'hF, 1'b0);
    set_w(1, 32'h1122_3344, 4'hF, 1'b1);
    wr(32'h8000_0020, 8'd1, 3'd2, 2'b01, 4'd7, 2'b00);
    set_w(0, 32'hAABB_CCDD, 4'b0100, 1'b0);
    set_w(1, 32'hAABB_CCDD, 4'b0101, 1'b1);
    wr(32'h8000_0020, 8'd1, 3'd2, 2'b01, 4'd8, 2'b00);
    set_w(0, 32'hFFFF_FFFF, 4'b0000, 1'b1);
    wr(32'h8000_0024, 8'd0, 3'd2, 2'b01, 4'd9, 2'b00);
    set_r(0, 32'h11BB_3344, 2'b00);
    set_r(1, 32'h11BB_33DD, 2'b00);
    rd_issue(32'h8000_0020, 8'd1, 3'd2, 2'b01, 4'd10, 1'b1);
    rd_collect(2, 0, -1);

    // Simultaneous AR and AW: the read goes first, the write waits
    araddr = 32'h8000_0000; arlen = 0; arsize = 2; arburst = 1; arid = 4'd11;
    awaddr = 32'h8000_0030; awlen = 0; awsize = 2; awburst = 1; awid = 4'd12;
    arvalid = 1'b1;
    awvalid = 1'b1;
    #1;
    chk("both_arready", arready, 1'b1);
    chk("both_awready", awready, 1'b0);
    set_r(0, 32'hDEAD_BEEF, 2'b00);
    rd_issue(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd11, 1'b1);
    chk("aw_held_in_read", awready, 1'b0);
    rd_collect(1, 0, 1 + RD_LAT);
    chk("aw_after_read", awready, 1'b1);
    set_w(0, 32'h0000_0055, 4'hF, 1'b1);
    wr(32'h8000_0030, 8'd0, 3'd2, 2'b01, 4'd12, 2'b00);
    set_r(0, 32'h0000_0055, 2'b00);
    rd_issue(32'h8000_0030, 8'd0, 3'd2, 2'b01, 4'd13, 1'b1);
    rd_collect(1, 0, -1);

    // Out of range reads, below the base and just past the end
    set_r(0, 32'h0, 2'b11);
    rd_issue(32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 4'd1, 1'b1);
    rd_collect(1, 0, 1 + RD_LAT);
    rd_issue(32'h8000_0000 + 32'(4 * DEPTH), 8'd0, 3'd2, 2'b01, 4'd2, 1'b1);
    rd_collect(1, 0, -1);

    // 2-beat write straddling the top: beat 0 lands, beat 1 is dropped
    set_w(0, 32'hCAFE_0001, 4'hF, 1'b0);
    set_w(1, 32'hCAFE_0002, 4'hF, 1'b1);
    wr(32'h8000_0000 + 32'(4 * DEPTH - 4), 8'd1, 3'd2, 2'b01, 4'd3, 2'b11);
    set_r(0, 32'hCAFE_0001, 2'b00);
    rd_issue(32'h8000_0000 + 32'(4 * DEPTH - 4), 8'd0, 3'd2, 2'b01, 4'd4, 1'b1);
    rd_collect(1, 0, -1);
    set_r(0, 32'hDEAD_BEEF, 2'b00);
    rd_issue(32'h8000_0000, 8'd0, 3'd2, 2'b01, 4'd5, 1'b1);
    rd_collect(1, 0, -1);

    // rready held low for 5 cycles on the first beat
    set_r(0, 32'd1, 2'b00);
    set_r(1, 32'd2, 2'b00);
    rd_issue(32'h8000_0010, 8'd1, 3'd2, 2'b01, 4'd6, 1'b1);
    rd_collect(2, 5, 1 + RD_LAT);

    // wlast on beat 0 of a 2-beat burst: both beats taken, SLVERR
    set_w(0, 32'd7, 4'hF, 1'b1);
    set_w(1, 32'd8, 4'hF, 1'b0);
    wr(32'h8000_0040, 8'd1, 3'd2, 2'b01, 4'd7, 2'b10);
    set_r(0, 32'd7, 2'b00);
    set_r(1, 32'd8, 2'b00);
    rd_issue(32'h8000_0040, 8'd1, 3'd2, 2'b01, 4'd8, 1'b1);
    rd_collect(2, 0, -1);

    // Reset while a read beat is waiting on rready
    rready = 1'b0;
    rd_issue(32'h8000_0010, 8'd0, 3'd2, 2'b01, 4'd9, 1'b0);
    begin
      int t;
      t = 0;
      while (!rvalid && t < 64) begin wait_clk(); t++; end
      chk("pre_reset_rvalid", rvalid, 1'b1);
    end
    #2;
    reset = 1'b1;
    #1;
    chk("async_rvalid", rvalid, 1'b0);
    chk("async_rlast", rlast, 1'b0);
    chk("async_rdata", rdata, 32'h0);
    chk("async_arready", arready, 1'b0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    chk("post_reset_arready", arready, 1'b1);
    set_r(0, 32'd7, 2'b00);
    rd_issue(32'h8000_0040, 8'd0, 3'd2, 2'b01, 4'd10, 1'b1);
    rd_collect(1, 0, 1 + RD_LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
